md5_match: RTL and testbench

- Downstream consumer of the md5core pipeline.
- Compares every hash result (a/b/c/d) against a host-loaded 128-bit target hash.
- On match, latches the 19-byte source message and its result index.
- Keeps a running count of hashes checked, for host readback and the search-done decision.

---
 rtl/md5_pkg.sv | 19 +
 rtl/md5_match_cmp.sv | 66 ++++++
 rtl/md5_match.sv | 207 ++++++++++++++++++++
 tb/tb_md5_match.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared widths, state encoding and target word addresses for the md5 search blocks.
package md5_pkg;

    localparam int MESG_W = 152;
    localparam int HASH_W = 128;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FOUND = 2'd2
    } match_state_e;

    localparam logic [1:0] TGT_A = 2'd0;
    localparam logic [1:0] TGT_B = 2'd1;
    localparam logic [1:0] TGT_C = 2'd2;
    localparam logic [1:0] TGT_D = 2'd3;

endpackage

// File: rtl/md5_match_cmp.sv
// Stage 1 of md5_match: registered 128-bit hash comparator plus message/index pipeline register.
module md5_match_cmp #(
    parameter int MESG_W = 152,
    parameter int CNT_W  = 32
) (
    input  logic                       clk_12mhz,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       armed,
    input  logic                       valid_in,
    input  logic [md5_pkg::WORD_W-1:0] a_in,
    input  logic [md5_pkg::WORD_W-1:0] b_in,
    input  logic [md5_pkg::WORD_W-1:0] c_in,
    input  logic [md5_pkg::WORD_W-1:0] d_in,
    input  logic [md5_pkg::HASH_W-1:0] target,
    input  logic [MESG_W-1:0]          m_in,
    input  logic [CNT_W-1:0]           idx_in,
    output logic                       valid_r,
    output logic                       eq_r,
    output logic [MESG_W-1:0]          mesg_r,
    output logic [CNT_W-1:0]           idx_r
);
    import md5_pkg::*;

    logic [HASH_W-1:0] hash_in;
    logic [3:0]        word_eq;
    logic              valid_q;
    logic              eq_q;
    logic [MESG_W-1:0] mesg_q;
    logic [CNT_W-1:0]  idx_q;

    assign hash_in = {a_in, b_in, c_in, d_in};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word_cmp
            assign word_eq[gi] = (hash_in[gi*WORD_W +: WORD_W] == target[gi*WORD_W +: WORD_W]);
        end
    endgenerate

    // flush overrides the enable so a restart always discards an in-flight result
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
            mesg_q  <= '0;
            idx_q   <= '0;
        end else begin
            if (en) begin
                valid_q <= valid_in & armed;
                eq_q    <= &word_eq;
                mesg_q  <= m_in;
                idx_q   <= idx_in;
            end
            if (flush) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_r = valid_q;
    assign eq_r    = eq_q;
    assign mesg_r  = mesg_q;
    assign idx_r   = idx_q;

endmodule

// File: rtl/md5_match.sv
// Compares md5core results against a host-loaded target hash and latches the matching message.
// Optional MD5_MATCH_MULTI_EN: keep searching after a match, adding match_count and match_pulse.
module md5_match #(
    parameter int MESG_W = md5_pkg::MESG_W,
    parameter int CNT_W  = 32
) (
    input  logic                       clk_12mhz,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       tgt_wr,
    input  logic [1:0]                 tgt_addr,
    input  logic [md5_pkg::WORD_W-1:0] tgt_data,
    input  logic                       start,
    input  logic                       clear,
    input  logic [md5_pkg::WORD_W-1:0] a_in,
    input  logic [md5_pkg::WORD_W-1:0] b_in,
    input  logic [md5_pkg::WORD_W-1:0] c_in,
    input  logic [md5_pkg::WORD_W-1:0] d_in,
    input  logic [MESG_W-1:0]          m_in,
    input  logic                       valid_in,
    output logic                       armed,
    output logic                       match_found,
    output logic [MESG_W-1:0]          match_mesg,
    output logic [CNT_W-1:0]           match_index,
    output logic [CNT_W-1:0]           hash_count
`ifdef MD5_MATCH_MULTI_EN
    ,
    output logic [15:0]                match_count,
    output logic                       match_pulse
`endif
);
    import md5_pkg::*;

    match_state_e      state_q, state_d;
    logic [HASH_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  hash_count_q, hash_count_d;
    logic [MESG_W-1:0] match_mesg_q, match_mesg_d;
    logic [CNT_W-1:0]  match_index_q, match_index_d;
    logic              restart;
    logic              take_match;
    logic              count_acc;
    logic              is_armed;
    logic              valid_r, eq_r;
    logic [MESG_W-1:0] mesg_r;
    logic [CNT_W-1:0]  idx_r;

    assign is_armed = (state_q == ST_ARMED);

    md5_match_cmp #(
        .MESG_W (MESG_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk_12mhz (clk_12mhz),
        .reset     (reset),
        .en        (en),
        .flush     (restart),
        .armed     (is_armed),
        .valid_in  (valid_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .target    (target_q),
        .m_in      (m_in),
        .idx_in    (hash_count_q),
        .valid_r   (valid_r),
        .eq_r      (eq_r),
        .mesg_r    (mesg_r),
        .idx_r     (idx_r)
    );

    // Target words are frozen while a search is running so the compare stays coherent
    always_comb begin
        target_d = target_q;
        if (tgt_wr && (state_q != ST_ARMED)) begin
            case (tgt_addr)
                TGT_A:   target_d[3*WORD_W +: WORD_W] = tgt_data;
                TGT_B:   target_d[2*WORD_W +: WORD_W] = tgt_data;
                TGT_C:   target_d[1*WORD_W +: WORD_W] = tgt_data;
                default: target_d[0*WORD_W +: WORD_W] = tgt_data;
            endcase
        end
    end

    // clear beats start, and start beats a pending stage-1 match
    always_comb begin
        state_d    = state_q;
        restart    = 1'b0;
        take_match = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!clear && start) begin
                    state_d = ST_ARMED;
                    restart = 1'b1;
                end
            end
            ST_ARMED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    restart = 1'b1;
                end else if (en && valid_r && eq_r) begin
                    take_match = 1'b1;
`ifndef MD5_MATCH_MULTI_EN
                    state_d    = ST_FOUND;
`endif
                end
            end
            ST_FOUND: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_ARMED;
                    restart = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In first-match mode the result arriving on the FOUND transition is not counted
    always_comb begin
        count_acc = en && valid_in && is_armed && !start && !clear;
`ifndef MD5_MATCH_MULTI_EN
        if (take_match) begin
            count_acc = 1'b0;
        end
`endif
        hash_count_d = hash_count_q;
        if (restart) begin
            hash_count_d = '0;
        end else if (count_acc && (hash_count_q != '1)) begin
            hash_count_d = hash_count_q + CNT_W'(1);
        end

        match_mesg_d  = match_mesg_q;
        match_index_d = match_index_q;
        if (restart) begin
            match_mesg_d  = '0;
            match_index_d = '0;
        end else if (take_match) begin
            match_mesg_d  = mesg_r;
            match_index_d = idx_r;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            hash_count_q  <= '0;
            match_mesg_q  <= '0;
            match_index_q <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            hash_count_q  <= hash_count_d;
            match_mesg_q  <= match_mesg_d;
            match_index_q <= match_index_d;
        end
    end

`ifdef MD5_MATCH_MULTI_EN
    logic        found_q, found_d;
    logic [15:0] match_count_q, match_count_d;
    logic        match_pulse_q;

    always_comb begin
        found_d       = found_q;
        match_count_d = match_count_q;
        if (restart || (state_d == ST_IDLE)) begin
            found_d = 1'b0;
        end else if (take_match) begin
            found_d = 1'b1;
        end
        if (restart) begin
            match_count_d = '0;
        end else if (take_match && (match_count_q != '1)) begin
            match_count_d = match_count_q + 16'(1);
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            found_q       <= 1'b0;
            match_count_q <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            found_q       <= found_d;
            match_count_q <= match_count_d;
            match_pulse_q <= take_match;
        end
    end

    assign match_found = found_q;
    assign match_count = match_count_q;
    assign match_pulse = match_pulse_q;
`else
    assign match_found = (state_q == ST_FOUND);
`endif

    assign armed       = is_armed;
    assign match_mesg  = match_mesg_q;
    assign match_index = match_index_q;
    assign hash_count  = hash_count_q;

endmodule

// File: tb/tb_md5_match.sv
// Self-checking bench for md5_match: vector table, scoreboard of expected matches, corner sequences.
module tb_md5_match;
    localparam int MESG_W = 152;
    localparam int CNT_W  = 32;
`ifdef MD5_MATCH_MULTI_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    localparam logic [MESG_W-1:0] MSG_HELLO = "Hello World 1234567";
    localparam logic [MESG_W-1:0] MSG_FOX   = "The quick brown fox";
    localparam logic [MESG_W-1:0] MSG_TEST  = "This is a test. 123";
    localparam logic [MESG_W-1:0] MSG_ZERO  = "zero hash result";

    logic              clk_12mhz = 1'b0;
    logic              reset, en, tgt_wr, start, clear, valid_in;
    logic [1:0]        tgt_addr;
    logic [31:0]       tgt_data, a_in, b_in, c_in, d_in;
    logic [MESG_W-1:0] m_in;
    logic              armed, match_found;
    logic [MESG_W-1:0] match_mesg;
    logic [CNT_W-1:0]  match_index, hash_count;
`ifdef MD5_MATCH_MULTI_EN
    logic [15:0]       match_count;
    logic              match_pulse;
`endif

    md5_match dut (
        .clk_12mhz   (clk_12mhz),
        .reset       (reset),
        .en          (en),
        .tgt_wr      (tgt_wr),
        .tgt_addr    (tgt_addr),
        .tgt_data    (tgt_data),
        .start       (start),
        .clear       (clear),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .d_in        (d_in),
        .m_in        (m_in),
        .valid_in    (valid_in),
        .armed       (armed),
        .match_found (match_found),
        .match_mesg  (match_mesg),
        .match_index (match_index),
        .hash_count  (hash_count)
`ifdef MD5_MATCH_MULTI_EN
        ,
        .match_count (match_count),
        .match_pulse (match_pulse)
`endif
    );

    always #41 clk_12mhz = ~clk_12mhz;

    typedef struct {
        logic [31:0]       a, b, c, d;
        logic [MESG_W-1:0] m;
    } res_t;

    typedef struct {
        res_t             r;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_found;
    } row_t;

    typedef struct {
        logic [CNT_W-1:0]  idx;
        logic [MESG_W-1:0] m;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulse_cnt = 0;
    exp_t exp_q[$];

    // reference model of the search state
    int               m_st = 0;
    logic [CNT_W-1:0] m_count = '0;
    logic [127:0]     m_tgt = '0;

    task automatic check(input string name, input logic [MESG_W-1:0] act, input logic [MESG_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk_12mhz);
        #1;
    endtask

    task automatic feed(input res_t r);
        a_in = r.a; b_in = r.b; c_in = r.c; d_in = r.d; m_in = r.m; valid_in = 1'b1;
        if (en && m_st == 1) begin
            if ({r.a, r.b, r.c, r.d} == m_tgt) begin
                exp_q.push_back('{idx: m_count, m: r.m});
                if (!MULTI) m_st = 2;
            end
            if (m_count != '1) m_count = m_count + 1;
        end
        $display("[TB] feed hash %h_%h_%h_%h", r.a, r.b, r.c, r.d);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic load_target(input res_t r);
        for (int i = 0; i < 4; i++) begin
            tgt_wr   = 1'b1;
            tgt_addr = 2'(i);
            tgt_data = (i == 0) ? r.a : (i == 1) ? r.b : (i == 2) ? r.c : r.d;
            tick();
        end
        tgt_wr = 1'b0;
        if (m_st != 1) m_tgt = {r.a, r.b, r.c, r.d};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_st = 1; m_count = '0; exp_q.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_st = 0; exp_q.delete();
    endtask

    // Scoreboard: each reported match must be the oldest expected one
    logic found_prev = 1'b0;
    always @(negedge clk_12mhz) begin
        logic ev;
        exp_t e;
`ifdef MD5_MATCH_MULTI_EN
        ev = match_pulse;
        if (ev) pulse_cnt++;
`else
        ev = match_found && !found_prev;
`endif
        found_prev = match_found;
        if (ev && !reset) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_match: got index %0h expected none", match_index);
            end else begin
                e = exp_q.pop_front();
                check("sb_index", match_index, e.idx);
                check("sb_mesg", match_mesg, e.m);
            end
        end
    end

    res_t V0, V1, V2, VNA, VND, VX, VZ;
    row_t rows[3];
    res_t pool[5];

    initial begin
        V0  = '{a: 32'hac98cf84, b: 32'h1c2e7a51, c: 32'h9d04b3e6, d: 32'h5f27c810, m: MSG_HELLO};
        V1  = '{a: 32'ha2004f37, b: 32'h730b9445, c: 32'h670a738f, d: 32'ha0fc9ee5, m: MSG_FOX};
        V2  = '{a: 32'hcaea4868, b: 32'h3b51d0a2, c: 32'h8e6f1147, d: 32'h02c9ab3d, m: MSG_TEST};
        VNA = '{a: 32'ha2004f36, b: 32'h730b9445, c: 32'h670a738f, d: 32'ha0fc9ee5, m: MSG_FOX};
        VND = '{a: 32'ha2004f37, b: 32'h730b9445, c: 32'h670a738f, d: 32'ha0fc9ee4, m: MSG_FOX};
        VX  = '{a: 32'h0badf00d, b: 32'h12345678, c: 32'h9abcdef0, d: 32'h0f1e2d3c, m: '0};
        VZ  = '{a: 32'h0, b: 32'h0, c: 32'h0, d: 32'h0, m: MSG_ZERO};
        rows[0] = '{r: V0, exp_cnt: 1, exp_found: 1'b0};
        rows[1] = '{r: V1, exp_cnt: 2, exp_found: 1'b0};
        rows[2] = '{r: V2, exp_cnt: MULTI ? 3 : 2, exp_found: 1'b1};
        pool = '{V0, V1, V2, VNA, VND};

        // reset, with a target write that must be ignored
        reset = 1'b1; en = 1'b1; start = 1'b0; clear = 1'b0; valid_in = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; m_in = '0;
        tgt_wr = 1'b1; tgt_addr = 2'd0; tgt_data = 32'hdeadbeef;
        tick(); tick(); tick();
        tgt_wr = 1'b0; reset = 1'b0;
        tick();
        check("rst_armed", armed, 0);
        check("rst_found", match_found, 0);
        check("rst_mesg", match_mesg, 0);
        check("rst_index", match_index, 0);
        check("rst_count", hash_count, 0);
`ifdef MD5_MATCH_MULTI_EN
        check("rst_match_count", match_count, 0);
        check("rst_pulse", match_pulse, 0);
`endif
        // target must still be zero: an all-zero hash matches
        pulse_start();
        feed(VZ);
        tick(); tick();
        check("rst_tgt_found", match_found, 1);
        pulse_clear();

        // first-match search over the vector table
        load_target(V1);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            feed(rows[i].r);
            check($sformatf("tbl%0d_count", i), hash_count, rows[i].exp_cnt);
            check($sformatf("tbl%0d_found", i), match_found, rows[i].exp_found);
        end
        tick();
        check("t2_armed", armed, MULTI);
        check("t2_index", match_index, 1);
        check("t2_mesg", match_mesg, MSG_FOX);

        // no matching result in ten
        if (MULTI) pulse_clear();
        load_target(VX);
        pulse_start();
        check("t3_restart_count", hash_count, 0);
        check("t3_restart_index", match_index, 0);
        check("t3_restart_mesg", match_mesg, 0);
        check("t3_restart_found", match_found, 0);
        for (int i = 0; i < 10; i++) feed(pool[i % 5]);
        tick(); tick();
        check("t3_found", match_found, 0);
        check("t3_count", hash_count, 10);
        check("t3_armed", armed, 1);
        pulse_clear();
        check("t3_clr_armed", armed, 0);
        check("t3_clr_count", hash_count, 10);

        // en stall with ignored valid results and ignored target writes
        load_target(V2);
        pulse_start();
        feed(V0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_in = V2.a; b_in = V2.b; c_in = V2.c; d_in = V2.d; m_in = V2.m; valid_in = 1'b1;
            tgt_wr = 1'b1; tgt_addr = 2'(i % 4);
            tgt_data = (i % 4 == 0) ? V0.a : (i % 4 == 1) ? V0.b : (i % 4 == 2) ? V0.c : V0.d;
            tick();
        end
        valid_in = 1'b0; tgt_wr = 1'b0; en = 1'b1;
        tick();
        check("t4_stall_count", hash_count, 1);
        check("t4_stall_found", match_found, 0);
        feed(V0);
        feed(V2);
        tick(); tick();
        check("t4_found", match_found, 1);
        check("t4_index", match_index, 2);
        check("t4_count", hash_count, 3);

        // start right after a matching result cancels it
        pulse_clear();
        load_target(V1);
        pulse_start();
        feed(V1);
        pulse_start();
        tick(); tick();
        check("t5_start_found", match_found, 0);
        check("t5_start_armed", armed, 1);
        check("t5_start_count", hash_count, 0);
        // clear in the cycle after a matching result drops the match
        feed(V1);
        pulse_clear();
        tick(); tick();
        check("t5_clear_found", match_found, 0);
        check("t5_clear_armed", armed, 0);
        check("t5_clear_count", hash_count, 1);
        // clear beats start
        pulse_start();
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        m_st = 0; exp_q.delete();
        check("t5_both_armed", armed, 0);
        check("t5_both_found", match_found, 0);

        // hash_count saturation
        pulse_start();
        force dut.hash_count_q = 32'hFFFF_FFFD;
        tick();
        release dut.hash_count_q;
        m_count = 32'hFFFF_FFFD;
        feed(V0);
        check("sat_fffffffe", hash_count, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            feed(V0);
            check($sformatf("sat_hold%0d", i), hash_count, 32'hFFFF_FFFF);
        end
        feed(V1);
        tick(); tick();
        check("sat_found", match_found, 1);
        check("sat_index", match_index, 32'hFFFF_FFFF);

`ifdef MD5_MATCH_MULTI_EN
        // multiple matches: keep searching, report the latest
        pulse_clear();
        load_target(V1);
        pulse_start();
        pulse_cnt = 0;
        feed(V1);
        feed(V0);
        feed(V1);
        tick(); tick(); tick();
        check("multi_count", match_count, 2);
        check("multi_pulses", pulse_cnt, 2);
        check("multi_index", match_index, 2);
        check("multi_found", match_found, 1);
        check("multi_armed", armed, 1);
        pulse_start();
        check("multi_restart_count", match_count, 0);
        check("multi_restart_found", match_found, 0);
`endif

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
